// File: rtl/uart_tx_pixel_if.sv
// Pixel handshake bundle for uart_tx_pixel: 24-bit RGB pixel with valid/ready.
// master drives pixels (upstream logic), slave accepts them (the transmitter).
interface uart_tx_pixel_if;
   logic [23:0] pixel;
   logic        pixel_valid;
   logic        pixel_ready;

   modport master (
      output pixel,
      output pixel_valid,
      input  pixel_ready
   );

   modport slave (
      input  pixel,
      input  pixel_valid,
      output pixel_ready
   );
endinterface

// File: rtl/uart_tx_pixel.sv
// UART transmitter: sends one 24-bit RGB pixel as three bytes (red, green, blue),
// LSB first, idle-high line. Define UART_TX_PARITY_EN for 8E1 frames (even parity
// bit between D7 and stop); default is 8N1.
module uart_tx_pixel #(
   parameter int unsigned CLK_FREQUENCY = 100000000,
   parameter int unsigned BAUD_RATE     = 115200
) (
   input  logic           clock,
   input  logic           reset,
   uart_tx_pixel_if.slave pix,
   output logic           uart_out_cable,
   output logic           busy,
   output logic           done
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
   localparam int unsigned DIV_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(CLKS_PER_BIT - 1);
   // The final stop bit of a pixel ends one cycle early in STOP; its last cycle is
   // the IDLE/done cycle, so a back-to-back pixel keeps exactly one stop period.
   localparam logic [DIV_W-1:0] DIV_STOP_END = DIV_W'(CLKS_PER_BIT - 2);

   if (CLKS_PER_BIT < 2) begin : g_bad_cfg
      $error("uart_tx_pixel: CLKS_PER_BIT must be >= 2");
   end

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop
`ifdef UART_TX_PARITY_EN
      , StParity
`endif
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       byte_q, byte_d;
   logic [2:0]       bit_q, bit_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [23:0]      pixel_q, pixel_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic             bit_end;
   logic [7:0]       tx_byte;

   function automatic logic [7:0] byte_sel(input logic [23:0] px, input logic [1:0] idx);
      case (idx)
         2'd0:    return px[23:16];
         2'd1:    return px[15:8];
         default: return px[7:0];
      endcase
   endfunction

   // State register with asynchronous reset; aborts any pixel in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         byte_q  <= '0;
         bit_q   <= '0;
         div_q   <= '0;
         pixel_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         byte_q  <= byte_d;
         bit_q   <= bit_d;
         div_q   <= div_d;
         pixel_q <= pixel_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; the line register is loaded from the next state so the
   // start bit appears in the cycle right after acceptance.
   always_comb begin
      state_d = state_q;
      byte_d  = byte_q;
      bit_d   = bit_q;
      div_d   = div_q + DIV_W'(1);
      pixel_d = pixel_q;
      done_d  = 1'b0;
      bit_end = (div_q == DIV_LAST);

      case (state_q)
         StIdle: begin
            div_d = '0;
            if (pix.pixel_valid) begin
               state_d = StStart;
               pixel_d = pix.pixel;
               byte_d  = '0;
               bit_d   = '0;
            end
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
               div_d   = '0;
               bit_d   = '0;
            end
         end
         StData: begin
            if (bit_end) begin
               div_d = '0;
               if (bit_q == 3'd7) begin
                  bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_end) begin
               state_d = StStop;
               div_d   = '0;
            end
         end
`endif
         StStop: begin
            if (byte_q == 2'd2) begin
               if (div_q == DIV_STOP_END) begin
                  state_d = StIdle;
                  div_d   = '0;
                  byte_d  = '0;
                  done_d  = 1'b1;
               end
            end else if (bit_end) begin
               state_d = StStart;
               div_d   = '0;
               byte_d  = byte_q + 2'd1;
            end
         end
         default: begin
            state_d = StIdle;
            div_d   = '0;
         end
      endcase

      tx_byte = byte_sel(pixel_d, byte_d);
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = tx_byte[bit_d];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = ^tx_byte;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   // Outputs.
   always_comb begin
      pix.pixel_ready = (state_q == StIdle) & ~reset;
      busy            = (state_q != StIdle);
      uart_out_cable  = tx_q;
      done            = done_q;
   end

endmodule

// File: tb/tb_uart_tx_pixel.sv
// Self-checking bench for uart_tx_pixel (CLKS_PER_BIT = 10). A tracker pushes the
// expected bytes and start times of every accepted pixel; a line decoder pops and
// compares them. Handshake/busy/done are checked every cycle against a timing model.
module tb_uart_tx_pixel;
   localparam int N = 10;
`ifdef UART_TX_PARITY_EN
   localparam int F = 11;
`else
   localparam int F = 10;
`endif
   localparam int P = 3 * F * N;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic uart_out_cable, busy, done;

   uart_tx_pixel_if pif ();

   uart_tx_pixel #(
      .CLK_FREQUENCY(1000),
      .BAUD_RATE    (100)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .pix           (pif),
      .uart_out_cable(uart_out_cable),
      .busy          (busy),
      .done          (done)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] exp_b[$];
   int         exp_t[$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Timing model and scoreboard push: a pixel accepted in cycle a occupies
   // cycles a+1 .. a+P-1 as busy, done in cycle a+P, byte k starts at a+1+k*F*N.
   int  n = 0;
   int  acc_n = 0;
   bit  acc_active = 0;
   always @(negedge clock) begin
      bit m_busy, m_done;
      n++;
      if (reset) begin
         acc_active = 0;
         exp_b.delete();
         exp_t.delete();
         check("reset_line", uart_out_cable, 1);
         check("reset_ready", pif.pixel_ready, 0);
         check("reset_busy", busy, 0);
         check("reset_done", done, 0);
      end else begin
         m_busy = acc_active && (n > acc_n) && (n < acc_n + P);
         m_done = acc_active && (n == acc_n + P);
         check("ready", pif.pixel_ready, int'(!m_busy));
         check("busy", busy, int'(m_busy));
         check("done", done, int'(m_done));
         if (!m_busy) check("idle_line", uart_out_cable, 1);
         if (pif.pixel_valid && !m_busy) begin
            acc_active = 1;
            acc_n      = n;
            for (int k = 0; k < 3; k++) begin
               exp_b.push_back(8'(pif.pixel >> (16 - 8 * k)));
               exp_t.push_back(n + 1 + k * F * N);
            end
         end
      end
   end

   // Line decoder: samples mid-bit, pops and compares at the end of each frame.
   int          dn = 0;
   int          t0 = 0;
   bit          dec_on = 0;
   logic        prev_line = 1'b1;
   logic [10:0] bits = '0;
   always @(negedge clock) begin
      int off;
      logic [7:0] eb;
      int et;
      dn++;
      if (reset) begin
         dec_on    = 0;
         prev_line = 1'b1;
      end else begin
         if (dec_on) begin
            off = dn - t0;
            if (off % N == N / 2) begin
               bits[off / N] = uart_out_cable;
               if (off / N == F - 1) begin
                  dec_on = 0;
                  if (exp_b.size() == 0) begin
                     check("frame_expected", 0, 1);
                  end else begin
                     eb = exp_b.pop_front();
                     et = exp_t.pop_front();
                     check("start_time", t0, et);
                     check("start_bit", bits[0], 0);
                     check("data_byte", bits[8:1], eb);
`ifdef UART_TX_PARITY_EN
                     check("parity_bit", bits[9], int'(^eb));
`endif
                     check("stop_bit", bits[F-1], 1);
                  end
               end
            end
         end else if (prev_line && !uart_out_cable) begin
            dec_on = 1;
            t0     = dn;
            bits   = '0;
         end
         prev_line = uart_out_cable;
      end
   end

   // Caller is at posedge+1. Presents px until accepted; keep leaves valid high.
   task automatic send_pixel(input logic [23:0] px, input bit keep);
      int g = 0;
      pif.pixel       = px;
      pif.pixel_valid = 1'b1;
      while (!pif.pixel_ready && g < 2000) begin
         @(posedge clock);
         #1;
         g++;
      end
      if (g >= 2000) check("ready_timeout", pif.pixel_ready, 1);
      @(posedge clock);
      #1;
      if (!keep) pif.pixel_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 2000) begin
         @(posedge clock);
         #1;
         g++;
      end
      if (g >= 2000) check("idle_timeout", busy, 0);
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
   endtask

   initial begin
      repeat (100000) @(posedge clock);
      n_err++;
      $display("FAIL watchdog: actual timeout required finish");
      summary();
      $fatal(1);
   end

   initial begin
      bit keep;
      pif.pixel       = '0;
      pif.pixel_valid = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (50) @(posedge clock);
      #1;

      // Single pixel, valid for one cycle.
      send_pixel(24'hA53C0F, 1'b0);
      wait_idle();

      // Back-to-back with valid held high.
      send_pixel(24'h010203, 1'b1);
      send_pixel(24'hFFFFFF, 1'b0);
      wait_idle();

      // Input changes while busy are ignored.
      send_pixel(24'h123456, 1'b0);
      repeat (4) @(posedge clock);
      #1;
      pif.pixel = 24'h000000;
      wait_idle();

      // Abort with reset during byte 1, bit D3 (F0 has D3 = 0).
      send_pixel(24'h5AF077, 1'b0);
      repeat (144) @(posedge clock);
      check("pre_abort_line", uart_out_cable, 0);
      #3;
      reset = 1'b1;
      #1;
      check("async_line", uart_out_cable, 1);
      check("async_busy", busy, 0);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      send_pixel(24'hC0FFEE, 1'b0);
      wait_idle();

`ifdef UART_TX_PARITY_EN
      send_pixel(24'h010300, 1'b0);
      wait_idle();
`endif

      // Randomized pixels, gaps and back-to-back runs.
      for (int i = 0; i < 8; i++) begin
         keep = (i < 7) && ($urandom_range(0, 2) == 0);
         send_pixel(24'($urandom), keep);
         if (!keep) begin
            if ($urandom_range(0, 1) == 1) wait_idle();
            repeat ($urandom_range(0, 5)) @(posedge clock);
            #1;
         end
      end
      wait_idle();
      repeat (5) @(posedge clock);
      #1;
      check("exp_queue_empty", exp_b.size(), 0);
      summary();
      $finish;
   end
endmodule

// File: doc/uart_tx_pixel.md
Name: uart_tx_pixel

Overview:
- UART transmitter that serialises one 24-bit RGB pixel as three 8N1 bytes, in the order red, green, blue.
- It is the outbound counterpart of the pixel receive path and sends frame/pixel data back to the host over the same 115200-baud link.
- Bit timing comes from an internal integer clock divider. A valid/ready handshake accepts pixels from upstream logic.

Parameters:
- CLK_FREQUENCY, 100000000: clock frequency in Hz.
- BAUD_RATE, 115200: line bit rate.
- CLKS_PER_BIT, CLK_FREQUENCY/BAUD_RATE (868 at defaults): derived localparam giving clock cycles per bit. Must be >= 2; elaboration error otherwise.

Ports:
- clock, input, 1: system clock (100 MHz at defaults).
- reset, input, 1: reset, asynchronous, active-high.
- pixel, input, 24: {red[23:16], green[15:8], blue[7:0]}.
- pixel_valid, input, 1: pixel presents valid data.
- pixel_ready, output, 1: block can accept a pixel this cycle.
- uart_out_cable, output, 1: serial TX line, idle high, registered.
- busy, output, 1: high while a pixel is being transmitted.
- done, output, 1: one-cycle pulse when the last stop bit of a pixel completes.

Behaviour:
- Reset values: uart_out_cable=1, busy=0, done=0, state=IDLE, byte index=0, bit counter=0, divider=0. pixel_ready=0 while reset is asserted and 1 in the first cycle after release.
- Async reset mid-transmission: the line returns to 1 immediately and the pixel is aborted with no done pulse. The next pixel starts cleanly after release.
- Handshake: a pixel is accepted on a rising clock edge with pixel_valid & pixel_ready. pixel_ready = (state==IDLE).
  - The pixel is latched into a 24-bit holding register. Input changes after acceptance are ignored.
  - pixel_valid while busy is not accepted. Upstream holds the pixel until ready.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on accept.
  - START: drive 0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: drive bits LSB first, each for CLKS_PER_BIT cycles. After bit 7 -> STOP.
  - STOP: drive 1 for CLKS_PER_BIT cycles. Then byte index 0 -> 1 -> 2 leads back to START with no idle gap. After byte index 2 -> IDLE.
- Byte select: index 0 = pixel[23:16], index 1 = pixel[15:8], index 2 = pixel[7:0].
- Latency: the start bit appears on uart_out_cable in the cycle after acceptance. A pixel occupies exactly 30*CLKS_PER_BIT cycles.
- Divider: counts 0..CLKS_PER_BIT-1 and restarts at every bit boundary. It is held at 0 in IDLE, so there is no fractional drift.
- done and return to IDLE:
  - done=1 for exactly one cycle, the first cycle back in IDLE. pixel_ready is also 1 in that cycle.
  - Back-to-back: if pixel_valid is high during that cycle, the next pixel is accepted there. Its start bit follows immediately, giving exactly one stop-bit period between pixels.
- busy = (state != IDLE).

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) is inserted between D7 and the stop bit, with an extra PARITY state. Frames are 8E1, and a pixel takes 33*CLKS_PER_BIT cycles.
- Undefined: 8N1 with no PARITY state, and a pixel takes 30*CLKS_PER_BIT cycles.

Test Plan (CLK_FREQUENCY=1000, BAUD_RATE=100, so CLKS_PER_BIT=10):
- Reset then idle 50 cycles -> uart_out_cable=1, pixel_ready=1, busy=0, done=0 throughout.
- Single pixel 24'hA5_3C_0F, valid for 1 cycle:
  - Line low from the next cycle for 10 cycles, then 1,0,1,0,0,1,0,1 (A5, LSB first) at 10 cycles each, then 1 for 10.
  - Then 3C, then 0F. done pulses at cycle 300 after acceptance.
  - The bench's sampling UART decoder returns A5, 3C, 0F.
- pixel_valid held high with pixels 24'h010203 then 24'hFFFFFF:
  - Second accept occurs in the done cycle.
  - Second start bit begins exactly 10 cycles after the last stop bit of 03 began.
  - Decoded bytes are 01, 02, 03, FF, FF, FF.
- Change pixel to 24'h000000 at cycle 5 while busy on 24'h123456 -> transmitted bytes remain 12, 34, 56, and pixel_ready stays 0 until done.
- Assert reset during byte 1 bit 3 -> uart_out_cable=1 asynchronously, no done pulse. After release, 24'hC0FFEE is transmitted correctly.
- With UART_TX_PARITY_EN defined, pixel 24'h010300:
  - Parity bits are 1 for 01, 0 for 03, 0 for 00.
  - done pulses 330 cycles after acceptance.
